// File: rtl/mem_bus_pkg.sv
// Shared types and default bus widths for the 6502 core / memory interface.
package mem_bus_pkg;

  // Default widths shared by the core, this controller and the 64kB memory model.
  localparam int MEM_ADDR_W = 16;
  localparam int MEM_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } mem_bus_state_t;

endpackage

// File: rtl/mem_bus_ctrl.sv
// Upstream bus controller: turns single valid/ready requests from the core
// into one memory access each, covers the memory's clocked read with fixed
// wait states and returns read data on a valid/ready response channel.
module mem_bus_ctrl
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W     = MEM_ADDR_W,
  parameter int DATA_W     = MEM_DATA_W,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req_valid,
  output logic              cpu_req_ready,
  input  logic [ADDR_W-1:0] cpu_req_addr,
  input  logic              cpu_req_we,
  input  logic [DATA_W-1:0] cpu_req_wdata,
  output logic              cpu_rsp_valid,
  input  logic              cpu_rsp_ready,
  output logic [DATA_W-1:0] cpu_rsp_rdata,
  output logic              mem_enable,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_wr_enable,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              busy
);

  // One extra bit so RD_LATENCY-1 always fits, including RD_LATENCY=1.
  localparam int CNT_W = $clog2(RD_LATENCY) + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LATENCY - 1);

  mem_bus_state_t    state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              men_nxt, mwe_nxt, rvalid_nxt, busy_nxt;
  logic [ADDR_W-1:0] maddr_nxt;
  logic [DATA_W-1:0] mwd_nxt, rdata_nxt;

  // Ready is a pure decode of state so the core sees it in the same cycle.
  assign cpu_req_ready = (state == IDLE);

  // Next-state and next-output decode; every registered output is computed here.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    men_nxt    = 1'b0;
    mwe_nxt    = mem_wr_enable;
    maddr_nxt  = mem_address;
    mwd_nxt    = mem_wr_data;
    rvalid_nxt = cpu_rsp_valid;
    rdata_nxt  = cpu_rsp_rdata;
    case (state)
      IDLE: begin
        if (cpu_req_valid) begin
          maddr_nxt = cpu_req_addr;
          mwe_nxt   = cpu_req_we;
          mwd_nxt   = cpu_req_wdata;
          men_nxt   = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        // The memory samples the access on this edge; write enable drops with
        // the enable so it is never left asserted while the bus sits idle.
        mwe_nxt = 1'b0;
        if (mem_wr_enable) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt   = CNT_LOAD;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          rdata_nxt  = mem_rd_data;
          rvalid_nxt = 1'b1;
          state_nxt  = RESP;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      RESP: begin
        if (cpu_rsp_ready) begin
          rvalid_nxt = 1'b0;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  // State, counter and registered outputs; reset drops any pending response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      mem_enable    <= 1'b0;
      mem_wr_enable <= 1'b0;
      mem_address   <= '0;
      mem_wr_data   <= '0;
      cpu_rsp_valid <= 1'b0;
      cpu_rsp_rdata <= '0;
      busy          <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      mem_enable    <= men_nxt;
      mem_wr_enable <= mwe_nxt;
      mem_address   <= maddr_nxt;
      mem_wr_data   <= mwd_nxt;
      cpu_rsp_valid <= rvalid_nxt;
      cpu_rsp_rdata <= rdata_nxt;
      busy          <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Bench for mem_bus_ctrl: two controllers (RD_LATENCY=1 and 3), each driving
// its own clocked-read memory, with a read-data scoreboard per controller.
module tb_mem_bus_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid_a, req_valid_b, req_we, rsp_ready;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;

  logic        req_ready_a, rsp_valid_a, men_a, mwe_a, busy_a;
  logic [7:0]  rdata_a, mwd_a, mrd_a;
  logic [15:0] maddr_a;
  logic        req_ready_b, rsp_valid_b, men_b, mwe_b, busy_b;
  logic [7:0]  rdata_b, mwd_b, mrd_b;
  logic [15:0] maddr_b;

  logic [7:0]  mem_a [0:65535];
  logic [7:0]  mem_b [0:65535];

  int          checks = 0;
  int          failures = 0;
  int          overlaps = 0;
  logic        men_prev_a = 1'b0, men_prev_b = 1'b0;
  logic [7:0]  q_a[$];
  logic [7:0]  q_b[$];

  // Selected-DUT views used by the shared tasks.
  logic        sel;
  logic        s_men, s_mwe, s_rv, s_rdy, s_bsy;
  logic [15:0] s_maddr;
  logic [7:0]  s_mwd, s_rd;
  assign s_men   = sel ? men_b       : men_a;
  assign s_mwe   = sel ? mwe_b       : mwe_a;
  assign s_rv    = sel ? rsp_valid_b : rsp_valid_a;
  assign s_rdy   = sel ? req_ready_b : req_ready_a;
  assign s_bsy   = sel ? busy_b      : busy_a;
  assign s_maddr = sel ? maddr_b     : maddr_a;
  assign s_mwd   = sel ? mwd_b       : mwd_a;
  assign s_rd    = sel ? rdata_b     : rdata_a;

  always #5 clk = ~clk;

  mem_bus_ctrl #(.ADDR_W(16), .DATA_W(8), .RD_LATENCY(1)) dut_a (
    .clk(clk), .reset(reset),
    .cpu_req_valid(req_valid_a), .cpu_req_ready(req_ready_a),
    .cpu_req_addr(req_addr), .cpu_req_we(req_we), .cpu_req_wdata(req_wdata),
    .cpu_rsp_valid(rsp_valid_a), .cpu_rsp_ready(rsp_ready), .cpu_rsp_rdata(rdata_a),
    .mem_enable(men_a), .mem_address(maddr_a), .mem_wr_enable(mwe_a),
    .mem_wr_data(mwd_a), .mem_rd_data(mrd_a), .busy(busy_a)
  );

  mem_bus_ctrl #(.ADDR_W(16), .DATA_W(8), .RD_LATENCY(3)) dut_b (
    .clk(clk), .reset(reset),
    .cpu_req_valid(req_valid_b), .cpu_req_ready(req_ready_b),
    .cpu_req_addr(req_addr), .cpu_req_we(req_we), .cpu_req_wdata(req_wdata),
    .cpu_rsp_valid(rsp_valid_b), .cpu_rsp_ready(rsp_ready), .cpu_rsp_rdata(rdata_b),
    .mem_enable(men_b), .mem_address(maddr_b), .mem_wr_enable(mwe_b),
    .mem_wr_data(mwd_b), .mem_rd_data(mrd_b), .busy(busy_b)
  );

  // Clocked-read memory models.
  always @(posedge clk) begin
    if (men_a) begin
      if (mwe_a) mem_a[maddr_a] <= mwd_a;
      mrd_a <= mem_a[maddr_a];
    end
    if (men_b) begin
      if (mwe_b) mem_b[maddr_b] <= mwd_b;
      mrd_b <= mem_b[maddr_b];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard pops on each response handshake; also tracks enable overlap.
  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      if (men_a && men_prev_a) overlaps++;
      if (men_b && men_prev_b) overlaps++;
      if (rsp_valid_a && rsp_ready) begin
        if (q_a.size() == 0) chk("sb_a_unexpected", 1, 0);
        else chk("sb_a_rdata", rdata_a, q_a.pop_front());
      end
      if (rsp_valid_b && rsp_ready) begin
        if (q_b.size() == 0) chk("sb_b_unexpected", 1, 0);
        else chk("sb_b_rdata", rdata_b, q_b.pop_front());
      end
    end
    men_prev_a = men_a;
    men_prev_b = men_b;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_valid(input logic v);
    req_valid_a = v & ~sel;
    req_valid_b = v & sel;
  endtask

  task automatic do_write(input logic [15:0] a, input logic [7:0] d);
    req_addr = a; req_wdata = d; req_we = 1'b1;
    set_valid(1'b1);
    tick();
    set_valid(1'b0);
    chk("wr_men", s_men, 1);
    chk("wr_mwe", s_mwe, 1);
    chk("wr_addr", s_maddr, a);
    chk("wr_data", s_mwd, d);
    chk("wr_busy", s_bsy, 1);
    chk("wr_rdy_low", s_rdy, 0);
    tick();
    chk("wr_men_drop", s_men, 0);
    chk("wr_mwe_drop", s_mwe, 0);
    chk("wr_rdy_back", s_rdy, 1);
    chk("wr_busy_drop", s_bsy, 0);
    chk("wr_no_rsp", s_rv, 0);
  endtask

  // Called right after the accepting edge of a read.
  task automatic finish_read(input logic [15:0] a, input logic [7:0] exp, input int stall);
    int lat;
    chk("rd_men", s_men, 1);
    chk("rd_mwe", s_mwe, 0);
    chk("rd_addr", s_maddr, a);
    lat = 1;
    while (!s_rv && lat < 20) begin
      tick();
      lat++;
    end
    chk("rd_valid_seen", s_rv, 1);
    chk("rd_latency", lat, sel ? 5 : 3);
    chk("rd_rdata", s_rd, exp);
    if (stall == 0) begin
      tick();
      chk("rd_valid_1cyc", s_rv, 0);
      chk("rd_rdy_back", s_rdy, 1);
    end else begin
      for (int i = 0; i < stall; i++) begin
        chk("stall_valid", s_rv, 1);
        chk("stall_rdata", s_rd, exp);
        chk("stall_busy", s_bsy, 1);
        chk("stall_rdy", s_rdy, 0);
        tick();
      end
      chk("stall_valid_end", s_rv, 1);
      rsp_ready = 1'b1;
      tick();
      chk("stall_release_valid", s_rv, 0);
      chk("stall_release_rdy", s_rdy, 1);
      chk("stall_release_rdata", s_rd, exp);
    end
    chk("rd_busy_drop", s_bsy, 0);
  endtask

  task automatic do_read(input logic [15:0] a, input logic [7:0] exp, input int stall);
    if (sel) q_b.push_back(exp); else q_a.push_back(exp);
    req_addr = a; req_we = 1'b0;
    rsp_ready = (stall == 0);
    set_valid(1'b1);
    tick();
    set_valid(1'b0);
    finish_read(a, exp, stall);
  endtask

  // Write then read with valid held high across both requests.
  task automatic back_to_back(input logic [15:0] a, input logic [7:0] d);
    if (sel) q_b.push_back(d); else q_a.push_back(d);
    rsp_ready = 1'b1;
    req_addr = a; req_wdata = d; req_we = 1'b1;
    set_valid(1'b1);
    tick();
    chk("b2b_wr_men", s_men, 1);
    req_we = 1'b0;
    tick();
    chk("b2b_gap_men", s_men, 0);
    chk("b2b_gap_rdy", s_rdy, 1);
    tick();
    set_valid(1'b0);
    finish_read(a, d, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    sel = 1'b0;
    req_valid_a = 1'b0; req_valid_b = 1'b0;
    req_we = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
    mem_a[16'hFFFF] = 8'h3C;
    mem_b[16'hFFFF] = 8'h3C;
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    chk("post_reset_rdy", req_ready_a, 1);

    // 1: asynchronous reset in the middle of an access
    req_addr = 16'h0300; req_wdata = 8'h77; req_we = 1'b1;
    set_valid(1'b1);
    tick();
    set_valid(1'b0);
    chk("pre_rst_busy", busy_a, 1);
    #2 reset = 1'b1;
    #1;
    chk("rst_men", men_a, 0);
    chk("rst_mwe", mwe_a, 0);
    chk("rst_addr", maddr_a, 0);
    chk("rst_wdata", mwd_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_rv", rsp_valid_a, 0);
    chk("rst_rdata", rdata_a, 0);
    chk("rst_rdy", req_ready_a, 1);
    tick();
    reset = 1'b0;
    tick();
    chk("rst_release_rdy", req_ready_a, 1);

    // 2-4: write, read back, stalled read of preloaded top address
    do_write(16'h0200, 8'hA5);
    do_read(16'h0200, 8'hA5, 0);
    do_read(16'hFFFF, 8'h3C, 5);

    // 5: back-to-back write/read at both latencies
    back_to_back(16'h0010, 8'h11);
    sel = 1'b1;
    back_to_back(16'h0010, 8'h22);

    // 6: reset during WAIT drops the response
    req_addr = 16'h0010; req_we = 1'b0; rsp_ready = 1'b1;
    set_valid(1'b1);
    tick();
    set_valid(1'b0);
    tick();
    chk("wait_busy", busy_b, 1);
    #2 reset = 1'b1;
    #1;
    chk("wait_rst_rv", rsp_valid_b, 0);
    chk("wait_rst_busy", busy_b, 0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("wait_rst_no_rsp", rsp_valid_b, 0);
    end
    do_read(16'h0010, 8'h22, 0);
    do_read(16'hFFFF, 8'h3C, 2);

    repeat (2) tick();
    chk("sb_a_empty", q_a.size(), 0);
    chk("sb_b_empty", q_b.size(), 0);
    chk("men_overlap", overlaps, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
